// File: rtl/hyperbus_mem_pkg.sv
// Shared types and constants for the HyperBus memory responder.
package hyperbus_mem_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CA   = 3'd1,
      ST_LAT  = 3'd2,
      ST_RD   = 3'd3,
      ST_WR   = 3'd4,
      ST_RWR  = 3'd5,
      ST_DONE = 3'd6
   } mem_state_e;

   // 48-bit command/address, beat 0 in the top 16 bits
   typedef struct packed {
      logic        rd;
      logic        reg_space;
      logic        linear;
      logic [28:0] addr_hi;
      logic [12:0] rsvd;
      logic [2:0]  addr_lo;
   } ca_t;

   localparam int unsigned WrapWords = 16;
   localparam logic [1:0]  ReadRwds  = 2'b10;

endpackage

// File: rtl/hyperbus_mem_array.sv
// Word array with asynchronous read and byte-enabled synchronous write.
module hyperbus_mem_array #(
   parameter int unsigned AddrWidth = 10
) (
   input  logic                 clk_i,
   input  logic                 we_i,
   input  logic [1:0]           be_i,
   input  logic [AddrWidth-1:0] addr_i,
   input  logic [15:0]          wdata_i,
   output logic [15:0]          rdata_o
);

   logic [15:0] mem [2**AddrWidth];

   assign rdata_o = mem[addr_i];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         if (be_i[1]) mem[addr_i][15:8] <= wdata_i[15:8];
         if (be_i[0]) mem[addr_i][7:0]  <= wdata_i[7:0];
      end
   end

endmodule

// File: rtl/hyperbus_mem_responder.sv
// HyperBus memory target on the word-level (one 16-bit word per CK beat) view.
//
// state   | meaning
// IDLE    | deselected, waiting for cs_ni low
// CA      | collecting the three command/address beats
// LAT     | initial latency, counting down Ltot beats
// RD      | read burst, one word loaded per beat
// WR      | write burst, one word stored per beat
// RWR     | zero-latency register write, first beat loads CR0
// DONE    | register write complete, beats ignored until deselect
module hyperbus_mem_responder
   import hyperbus_mem_pkg::*;
#(
   parameter int unsigned AddrWidth     = 10,
   parameter int unsigned LatencyCycles = 6,
   parameter int unsigned FixedLatency  = 1,
   parameter logic [15:0] Cr0Reset      = 16'h8F1F
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        cs_ni,
   input  logic        ck_ena_i,
   input  logic [15:0] dq_i,
   input  logic [1:0]  rwds_i,
   output logic [15:0] dq_o,
   output logic        dq_oe_o,
   output logic [1:0]  rwds_o,
   output logic        rwds_oe_o
);

   localparam int unsigned LatTot = LatencyCycles * ((FixedLatency != 0) ? 2 : 1);
   localparam int unsigned LatW   = (LatTot > 1) ? $clog2(LatTot) : 1;
   localparam logic [AddrWidth-1:0] WrapMask = AddrWidth'(WrapWords - 1);

   mem_state_e           state_q, state_d;
   logic [1:0]           ca_cnt_q, ca_cnt_d;
   logic [LatW-1:0]      lat_cnt_q, lat_cnt_d;
   logic [31:0]          ca_hi_q, ca_hi_d;
   logic                 rd_q, rd_d, reg_q, reg_d, lin_q, lin_d;
   logic [AddrWidth-1:0] addr_q, addr_d;
   logic [15:0]          cr0_q, cr0_d;
   logic [15:0]          dq_d;
   logic                 dq_oe_d, rwds_oe_d;
   logic [1:0]           rwds_d;
   logic                 mem_we;
   logic [15:0]          mem_rdata, rd_word;
   ca_t                  ca_w;
   logic                 ca_unused;

   // Third CA beat is decoded straight off the bus, no extra cycle
   assign ca_w      = {ca_hi_q, dq_i};
   assign ca_unused = ^ca_w;
   assign rd_word   = reg_q ? cr0_q : mem_rdata;

   function automatic logic [AddrWidth-1:0] next_addr(input logic [AddrWidth-1:0] a,
                                                     input logic                 lin);
      logic [AddrWidth-1:0] inc;
      inc = a + 1'b1;
      return lin ? inc : ((a & ~WrapMask) | (inc & WrapMask));
   endfunction

   hyperbus_mem_array #(.AddrWidth(AddrWidth)) u_array (
      .clk_i   (clk_i),
      .we_i    (mem_we),
      .be_i    (~rwds_i),
      .addr_i  (addr_q),
      .wdata_i (dq_i),
      .rdata_o (mem_rdata)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         ca_cnt_q  <= '0;
         lat_cnt_q <= '0;
         ca_hi_q   <= '0;
         rd_q      <= 1'b0;
         reg_q     <= 1'b0;
         lin_q     <= 1'b0;
         addr_q    <= '0;
         cr0_q     <= Cr0Reset;
         dq_o      <= '0;
         dq_oe_o   <= 1'b0;
         rwds_o    <= '0;
         rwds_oe_o <= 1'b0;
      end else begin
         state_q   <= state_d;
         ca_cnt_q  <= ca_cnt_d;
         lat_cnt_q <= lat_cnt_d;
         ca_hi_q   <= ca_hi_d;
         rd_q      <= rd_d;
         reg_q     <= reg_d;
         lin_q     <= lin_d;
         addr_q    <= addr_d;
         cr0_q     <= cr0_d;
         dq_o      <= dq_d;
         dq_oe_o   <= dq_oe_d;
         rwds_o    <= rwds_d;
         rwds_oe_o <= rwds_oe_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (cs_ni) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: state_d = ST_CA;
            ST_CA:   if (ck_ena_i && ca_cnt_q == 2'd0)
                        state_d = (!ca_w.rd && ca_w.reg_space) ? ST_RWR : ST_LAT;
            ST_LAT:  if (ck_ena_i && lat_cnt_q == '0)
                        state_d = rd_q ? ST_RD : ST_WR;
            ST_RWR:  if (ck_ena_i) state_d = ST_DONE;
            default: state_d = state_q;
         endcase
      end
   end

   always_comb begin
      ca_cnt_d  = ca_cnt_q;
      lat_cnt_d = lat_cnt_q;
      ca_hi_d   = ca_hi_q;
      rd_d      = rd_q;
      reg_d     = reg_q;
      lin_d     = lin_q;
      addr_d    = addr_q;
      cr0_d     = cr0_q;
      dq_d      = dq_o;
      dq_oe_d   = dq_oe_o;
      rwds_d    = rwds_o;
      rwds_oe_d = rwds_oe_o;
      mem_we    = 1'b0;
      if (cs_ni) begin
         dq_oe_d   = 1'b0;
         rwds_oe_d = 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: ca_cnt_d = 2'd2;
            ST_CA: if (ck_ena_i) begin
               if (ca_cnt_q != 2'd0) ca_cnt_d = ca_cnt_q - 2'd1;
               if (ca_cnt_q == 2'd2) begin
                  ca_hi_d[31:16] = dq_i;
                  rwds_oe_d      = 1'b1;
                  rwds_d         = {2{FixedLatency != 0}};
               end
               if (ca_cnt_q == 2'd1) ca_hi_d[15:0] = dq_i;
               if (ca_cnt_q == 2'd0) begin
                  rd_d      = ca_w.rd;
                  reg_d     = ca_w.reg_space;
                  lin_d     = ca_w.linear;
                  addr_d    = AddrWidth'({ca_w.addr_hi, ca_w.addr_lo});
                  lat_cnt_d = LatW'(LatTot - 1);
                  if (!ca_w.rd) rwds_oe_d = 1'b0;
               end
            end
            ST_LAT: if (ck_ena_i) begin
               if (lat_cnt_q != '0) begin
                  lat_cnt_d = lat_cnt_q - 1'b1;
               end else if (rd_q) begin
                  dq_d      = rd_word;
                  dq_oe_d   = 1'b1;
                  rwds_oe_d = 1'b1;
                  rwds_d    = ReadRwds;
                  addr_d    = next_addr(addr_q, lin_q);
               end
            end
            ST_RD: if (ck_ena_i) begin
               dq_d      = rd_word;
               dq_oe_d   = 1'b1;
               rwds_oe_d = 1'b1;
               rwds_d    = ReadRwds;
               addr_d    = next_addr(addr_q, lin_q);
            end
            ST_WR: if (ck_ena_i) begin
               mem_we = 1'b1;
               addr_d = next_addr(addr_q, lin_q);
            end
            ST_RWR: if (ck_ena_i) cr0_d = dq_i;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_hyperbus_mem_responder.sv
// Directed bench for hyperbus_mem_responder with immediate-assertion checks.
module tb_hyperbus_mem_responder;
   import hyperbus_mem_pkg::*;

   localparam int Ltot = 12;

   logic        clk_i = 1'b0;
   logic        rst_ni, cs_ni, ck_ena_i;
   logic [15:0] dq_i;
   logic [1:0]  rwds_i;
   logic [15:0] dq_o;
   logic        dq_oe_o;
   logic [1:0]  rwds_o;
   logic        rwds_oe_o;

   int n_assert = 0;
   int n_fail   = 0;

   typedef logic [15:0] w4_t [4];

   hyperbus_mem_responder dut (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .cs_ni     (cs_ni),
      .ck_ena_i  (ck_ena_i),
      .dq_i      (dq_i),
      .rwds_i    (rwds_i),
      .dq_o      (dq_o),
      .dq_oe_o   (dq_oe_o),
      .rwds_o    (rwds_o),
      .rwds_oe_o (rwds_oe_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic cs, input logic ena, input logic [15:0] d, input logic [1:0] m);
      cs_ni    = cs;
      ck_ena_i = ena;
      dq_i     = d;
      rwds_i   = m;
      @(posedge clk_i);
      #1;
   endtask

   task automatic start_ca(input bit rd, input bit rg, input bit lin, input logic [31:0] a);
      logic [47:0] c;
      c         = '0;
      c[47]     = rd;
      c[46]     = rg;
      c[45]     = lin;
      c[44:16]  = a[31:3];
      c[2:0]    = a[2:0];
      cyc(1'b0, 1'b0, 16'h0, 2'b00);
      cyc(1'b0, 1'b1, c[47:32], 2'b00);
      chk("ca_rwds_oe", 16'(rwds_oe_o), 16'h1);
      chk("ca_rwds", 16'(rwds_o), 16'h3);
      cyc(1'b0, 1'b1, c[31:16], 2'b00);
      cyc(1'b0, 1'b1, c[15:0], 2'b00);
      chk("ca_end_rwds_oe", 16'(rwds_oe_o), rd ? 16'h1 : 16'h0);
   endtask

   task automatic latency(input bit stall, input bit rd);
      for (int i = 0; i < Ltot; i++) begin
         if (stall) begin
            int gaps;
            gaps = $urandom_range(0, 2);
            for (int g = 0; g < gaps; g++) cyc(1'b0, 1'b0, 16'hFFFF, 2'b11);
         end
         cyc(1'b0, 1'b1, 16'h0, 2'b00);
         if (i == Ltot - 2) chk("lat_early_dq_oe", 16'(dq_oe_o), 16'h0);
      end
      chk("lat_done_dq_oe", 16'(dq_oe_o), rd ? 16'h1 : 16'h0);
   endtask

   task automatic end_txn();
      cyc(1'b1, 1'b0, 16'h0, 2'b00);
      chk("end_dq_oe", 16'(dq_oe_o), 16'h0);
      chk("end_rwds_oe", 16'(rwds_oe_o), 16'h0);
   endtask

   task automatic mem_write(input logic [31:0] a, input bit lin, input w4_t w, input int n,
                            input logic [1:0] m);
      start_ca(1'b0, 1'b0, lin, a);
      latency(1'b0, 1'b0);
      for (int k = 0; k < n; k++) cyc(1'b0, 1'b1, w[k], m);
      end_txn();
   endtask

   task automatic rd_burst(input logic [31:0] a, input bit rg, input bit lin, input w4_t w,
                           input int n, input bit stall);
      start_ca(1'b1, rg, lin, a);
      latency(stall, 1'b1);
      for (int k = 0; k < n; k++) begin
         if (stall && k > 0) begin
            int gaps;
            gaps = $urandom_range(1, 3);
            for (int g = 0; g < gaps; g++) cyc(1'b0, 1'b0, 16'hFFFF, 2'b11);
            chk("stall_dq_hold", dq_o, w[k]);
         end
         chk("rd_data", dq_o, w[k]);
         chk("rd_rwds", 16'(rwds_o), 16'(ReadRwds));
         cyc(1'b0, 1'b1, 16'h0, 2'b00);
      end
      end_txn();
   endtask

   initial begin
      rst_ni   = 1'b0;
      cs_ni    = 1'b1;
      ck_ena_i = 1'b0;
      dq_i     = '0;
      rwds_i   = '0;
      @(posedge clk_i);
      @(posedge clk_i);
      #1;
      chk("rst_dq", dq_o, 16'h0);
      chk("rst_dq_oe", 16'(dq_oe_o), 16'h0);
      chk("rst_rwds", 16'(rwds_o), 16'h0);
      chk("rst_rwds_oe", 16'(rwds_oe_o), 16'h0);
      rst_ni = 1'b1;
      cyc(1'b1, 1'b0, 16'h0, 2'b00);

      // CR0 reset value via register-space read
      rd_burst(32'h0, 1'b1, 1'b1, '{16'h8F1F, 16'h8F1F, 16'h0, 16'h0}, 2, 1'b0);

      // linear write / read
      mem_write(32'h010, 1'b1, '{16'h1111, 16'h2222, 16'h3333, 16'h4444}, 4, 2'b00);
      rd_burst(32'h010, 1'b0, 1'b1, '{16'h1111, 16'h2222, 16'h3333, 16'h4444}, 4, 1'b0);

      // byte mask: upper byte masked keeps 0xAA
      mem_write(32'h020, 1'b1, '{16'hAAAA, 16'h0, 16'h0, 16'h0}, 1, 2'b00);
      mem_write(32'h020, 1'b1, '{16'h1234, 16'h0, 16'h0, 16'h0}, 1, 2'b10);
      rd_burst(32'h020, 1'b0, 1'b1, '{16'hAA34, 16'h0, 16'h0, 16'h0}, 1, 1'b0);

      // wrapped read stays inside the 16-word group
      mem_write(32'h03E, 1'b1, '{16'hA03E, 16'hA03F, 16'hA040, 16'hA041}, 4, 2'b00);
      mem_write(32'h030, 1'b1, '{16'hA030, 16'hA031, 16'h0, 16'h0}, 2, 2'b00);
      rd_burst(32'h03E, 1'b0, 1'b0, '{16'hA03E, 16'hA03F, 16'hA030, 16'hA031}, 4, 1'b0);

      // linear burst wraps at the top of the array
      mem_write(32'h3FF, 1'b1, '{16'hC3FF, 16'hC000, 16'h0, 16'h0}, 2, 2'b00);
      rd_burst(32'h3FF, 1'b0, 1'b1, '{16'hC3FF, 16'hC000, 16'h0, 16'h0}, 2, 1'b0);
      rd_burst(32'h000, 1'b0, 1'b1, '{16'hC000, 16'h0, 16'h0, 16'h0}, 1, 1'b0);

      // zero-latency register write
      start_ca(1'b0, 1'b1, 1'b1, 32'h0);
      cyc(1'b0, 1'b1, 16'h8F17, 2'b00);
      cyc(1'b0, 1'b1, 16'h5555, 2'b00);
      end_txn();
      rd_burst(32'h1, 1'b1, 1'b1, '{16'h8F17, 16'h0, 16'h0, 16'h0}, 1, 1'b0);

      // abort after two read words; beat alongside cs_ni high is ignored
      start_ca(1'b1, 1'b0, 1'b1, 32'h010);
      latency(1'b0, 1'b1);
      chk("abort_w0", dq_o, 16'h1111);
      cyc(1'b0, 1'b1, 16'h0, 2'b00);
      chk("abort_w1", dq_o, 16'h2222);
      cyc(1'b0, 1'b1, 16'h0, 2'b00);
      cyc(1'b1, 1'b1, 16'h0, 2'b00);
      chk("abort_dq_oe", 16'(dq_oe_o), 16'h0);
      chk("abort_rwds_oe", 16'(rwds_oe_o), 16'h0);
      chk("abort_dq_hold", dq_o, 16'h3333);
      chk("abort_state", 16'(dut.state_q), 16'(ST_IDLE));
      rd_burst(32'h012, 1'b0, 1'b1, '{16'h3333, 16'h4444, 16'h0, 16'h0}, 2, 1'b0);

      // ck_ena gaps during latency and data
      rd_burst(32'h010, 1'b0, 1'b1, '{16'h1111, 16'h2222, 16'h3333, 16'h4444}, 4, 1'b1);
      rd_burst(32'h03E, 1'b0, 1'b0, '{16'hA03E, 16'hA03F, 16'hA030, 16'hA031}, 4, 1'b1);

      // reset in the middle of a write burst
      mem_write(32'h050, 1'b1, '{16'h5050, 16'h5151, 16'h0, 16'h0}, 2, 2'b00);
      start_ca(1'b0, 1'b0, 1'b1, 32'h050);
      latency(1'b0, 1'b0);
      cyc(1'b0, 1'b1, 16'hDEAD, 2'b00);
      rst_ni = 1'b0;
      #1;
      chk("mid_rst_dq", dq_o, 16'h0);
      chk("mid_rst_dq_oe", 16'(dq_oe_o), 16'h0);
      chk("mid_rst_rwds", 16'(rwds_o), 16'h0);
      chk("mid_rst_rwds_oe", 16'(rwds_oe_o), 16'h0);
      chk("mid_rst_state", 16'(dut.state_q), 16'(ST_IDLE));
      cyc(1'b0, 1'b1, 16'hBEEF, 2'b00);
      cyc(1'b0, 1'b1, 16'hBEEF, 2'b00);
      cyc(1'b1, 1'b0, 16'h0, 2'b00);
      rst_ni = 1'b1;
      cyc(1'b1, 1'b0, 16'h0, 2'b00);
      rd_burst(32'h050, 1'b0, 1'b1, '{16'hDEAD, 16'h5151, 16'h0, 16'h0}, 2, 1'b0);
      rd_burst(32'h0, 1'b1, 1'b1, '{16'h8F1F, 16'h0, 16'h0, 16'h0}, 1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
